// File: rtl/display_scan_scheduler.sv
// rtl/display_scan_scheduler.sv - frame-coherent 4-digit scan scheduler with anti-ghost blanking
module display_scan_scheduler #(
    parameter int REFRESH_DIV  = 50000,
    parameter int BLANK_CYCLES = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        funct_select,
    input  logic [15:0] cuenta_frec,
    input  logic [15:0] cuenta_CT,
    input  logic        upd_req,
    output logic        upd_ack,
    output logic [3:0]  digit_bcd,
    output logic [3:0]  code_7seg,
    output logic        source_ind
);

    localparam int MAXD = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
    localparam int CW   = (MAXD > 1) ? $clog2(MAXD) : 1;
    localparam logic [CW-1:0] SCAN_LOAD  = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] BLANK_LOAD = CW'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);

    typedef enum logic [1:0] {S_LOAD, S_SCAN, S_BLANK} state_t;

    state_t         state, state_n;
    logic [1:0]     digit, digit_n;
    logic [CW-1:0]  cnt, cnt_n;
    logic [15:0]    snap, snap_n;
    logic           pending, pending_n;
    logic           src_n, ack_n;
    logic [3:0]     bcd_n, en_n;

    // Leading-zero test uses raw nibbles, so A-F counts as non-zero.
    function automatic logic [3:0] disp(input logic [15:0] s, input logic [1:0] d);
        logic [3:0] n;
        logic       lz;
        case (d)
            2'd0:    begin n = s[3:0];   lz = 1'b0;             end
            2'd1:    begin n = s[7:4];   lz = (s[15:4] == '0);  end
            2'd2:    begin n = s[11:8];  lz = (s[15:8] == '0);  end
            default: begin n = s[15:12]; lz = (s[15:12] == '0); end
        endcase
        return (lz || n > 4'd9) ? 4'hF : n;
    endfunction

    always_comb begin
        state_n   = state;
        digit_n   = digit;
        cnt_n     = cnt;
        snap_n    = snap;
        src_n     = source_ind;
        pending_n = pending | upd_req;
        ack_n     = 1'b0;
        case (state)
            S_LOAD: begin
                snap_n    = funct_select ? cuenta_CT : cuenta_frec;
                src_n     = funct_select;
                ack_n     = pending | upd_req;
                pending_n = 1'b0;
                state_n   = S_SCAN;
                digit_n   = 2'd0;
                cnt_n     = SCAN_LOAD;
            end
            S_SCAN: begin
                if (cnt != '0) begin
                    cnt_n = cnt - 1'b1;
                end else if (BLANK_CYCLES > 0) begin
                    state_n = S_BLANK;
                    cnt_n   = BLANK_LOAD;
                end else if (digit == 2'd3) begin
                    state_n = S_LOAD;
                end else begin
                    digit_n = digit + 2'd1;
                    cnt_n   = SCAN_LOAD;
                end
            end
            default: begin
                if (cnt != '0) begin
                    cnt_n = cnt - 1'b1;
                end else if (digit == 2'd3) begin
                    state_n = S_LOAD;
                end else begin
                    state_n = S_SCAN;
                    digit_n = digit + 2'd1;
                    cnt_n   = SCAN_LOAD;
                end
            end
        endcase

        // Outputs are registered, so they are derived from the next state.
        bcd_n = 4'hF;
        en_n  = 4'hF;
        if (state_n == S_SCAN) begin
            en_n  = ~(4'b0001 << digit_n);
            bcd_n = disp(snap_n, digit_n);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= S_LOAD;
            digit      <= 2'd0;
            cnt        <= '0;
            snap       <= '0;
            pending    <= 1'b0;
            upd_ack    <= 1'b0;
            digit_bcd  <= 4'hF;
            code_7seg  <= 4'hF;
            source_ind <= 1'b0;
        end else begin
            state      <= state_n;
            digit      <= digit_n;
            cnt        <= cnt_n;
            snap       <= snap_n;
            pending    <= pending_n;
            upd_ack    <= ack_n;
            digit_bcd  <= bcd_n;
            code_7seg  <= en_n;
            source_ind <= src_n;
        end
    end

endmodule

// File: tb/tb_display_scan_scheduler.sv
// tb/tb_display_scan_scheduler.sv - directed and random checks against a frame-position model
module tb_display_scan_scheduler;

    localparam int R     = 4;
    localparam int B     = 2;
    localparam int FRAME = 4 * (R + B) + 1;

    logic        clock = 1'b0;
    logic        reset;
    logic        funct_select;
    logic [15:0] cuenta_frec;
    logic [15:0] cuenta_CT;
    logic        upd_req;
    logic        upd_ack;
    logic [3:0]  digit_bcd;
    logic [3:0]  code_7seg;
    logic        source_ind;

    int total = 0;
    int bad   = 0;

    // Model: position in frame, displayed value, source, pending, ack
    int m_pos;
    int m_snap;
    bit m_src, m_pend, m_ack;

    display_scan_scheduler #(.REFRESH_DIV(R), .BLANK_CYCLES(B)) dut (
        .clock(clock), .reset(reset), .funct_select(funct_select),
        .cuenta_frec(cuenta_frec), .cuenta_CT(cuenta_CT), .upd_req(upd_req),
        .upd_ack(upd_ack), .digit_bcd(digit_bcd), .code_7seg(code_7seg),
        .source_ind(source_ind)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] disp_exp(input int v, input int d);
        int hi;
        int n;
        hi = v >> (4 * d);
        n  = hi % 16;
        if (d > 0 && hi == 0) return 4'hF;
        if (n > 9) return 4'hF;
        return 4'(n);
    endfunction

    task automatic check_model();
        logic [3:0] e_en, e_bcd;
        int k, d, r;
        e_en  = 4'hF;
        e_bcd = 4'hF;
        if (m_pos != 0) begin
            k = m_pos - 1;
            d = k / (R + B);
            r = k % (R + B);
            if (r < R) begin
                e_en  = 4'hF ^ 4'(1 << d);
                e_bcd = disp_exp(m_snap, d);
            end
        end
        check("code_7seg", {12'd0, code_7seg}, {12'd0, e_en});
        check("digit_bcd", {12'd0, digit_bcd}, {12'd0, e_bcd});
        check("upd_ack", {15'd0, upd_ack}, {15'd0, m_ack});
        check("source_ind", {15'd0, source_ind}, {15'd0, m_src});
    endtask

    // One cycle: check current outputs, drive inputs, advance the model across the edge.
    task automatic cyc(input bit fs, input logic [15:0] fr, input logic [15:0] ct, input bit req);
        check_model();
        funct_select = fs;
        cuenta_frec  = fr;
        cuenta_CT    = ct;
        upd_req      = req;
        if (m_pos == 0) begin
            m_snap = fs ? int'(ct) : int'(fr);
            m_src  = fs;
            m_ack  = m_pend | req;
            m_pend = 0;
        end else begin
            m_pend = m_pend | req;
            m_ack  = 0;
        end
        m_pos = (m_pos + 1) % FRAME;
        @(negedge clock);
    endtask

    task automatic hold(input int n);
        for (int i = 0; i < n; i++) cyc(funct_select, cuenta_frec, cuenta_CT, 1'b0);
    endtask

    task automatic run_to(input int p);
        int guard = 0;
        while (m_pos != p && guard < 2 * FRAME) begin
            cyc(funct_select, cuenta_frec, cuenta_CT, 1'b0);
            guard++;
        end
        check("run_to_bound", 16'(m_pos), 16'(p));
    endtask

    task automatic model_reset();
        m_pos = 0; m_snap = 0; m_src = 0; m_pend = 0; m_ack = 0;
    endtask

    initial begin
        reset = 1'b1; funct_select = 1'b0; cuenta_frec = 16'h1234;
        cuenta_CT = 16'h0000; upd_req = 1'b0;
        model_reset();
        @(negedge clock);
        check_model();
        @(negedge clock);
        reset = 1'b0;

        // Basic scan: two full frames of 1234
        hold(2 * FRAME);

        // Leading zeros and non-BCD
        cyc(0, 16'h0050, 16'h0000, 1); hold(2 * FRAME);
        cyc(0, 16'h0000, 16'h0000, 1); hold(2 * FRAME);
        cyc(0, 16'h12A4, 16'h0000, 1); hold(2 * FRAME);
        cyc(0, 16'h1234, 16'h0000, 1); hold(FRAME);

        // Coherence: change mid-frame with a request
        run_to(10);
        cyc(0, 16'h5678, 16'h0000, 1);
        run_to(1);
        check("coh_digit", {12'd0, digit_bcd}, 16'h0008);
        check("coh_ack", {15'd0, upd_ack}, 16'h0001);
        hold(FRAME);

        // Source switch without request
        run_to(5);
        cyc(1, 16'h5678, 16'h0099, 0);
        run_to(0);
        check("src_hold", {15'd0, source_ind}, 16'h0000);
        cyc(1, 16'h5678, 16'h0099, 0);
        check("src_new", {15'd0, source_ind}, 16'h0001);
        check("src_noack", {15'd0, upd_ack}, 16'h0000);
        check("src_digit", {12'd0, digit_bcd}, 16'h0009);
        hold(FRAME);

        // Merge: three requests, one ack
        run_to(3);
        cyc(1, 16'h5678, 16'h0042, 1); hold(3);
        cyc(1, 16'h5678, 16'h0042, 1); hold(3);
        cyc(1, 16'h5678, 16'h0042, 1);
        run_to(1);
        check("merge_ack", {15'd0, upd_ack}, 16'h0001);
        hold(FRAME);

        // Request in LOAD cycle is honoured immediately
        run_to(0);
        cyc(0, 16'h0707, 16'h0042, 1);
        check("load_req_ack", {15'd0, upd_ack}, 16'h0001);
        hold(FRAME);

        // Randomised traffic
        for (int i = 0; i < 800; i++) begin
            logic [15:0] fr, ct;
            fr = 16'($urandom);
            ct = 16'($urandom);
            if ($urandom_range(0, 3) != 0) fr = fr & 16'h0F77;
            if ($urandom_range(0, 3) == 0) ct = 16'h0000;
            cyc(($urandom_range(0, 9) == 0) ? ~funct_select : funct_select,
                fr, ct, $urandom_range(0, 15) == 0);
        end

        // Asynchronous reset during SCAN(2)
        run_to(14);
        #2;
        reset = 1'b1;
        #1;
        check("rst_en", {12'd0, code_7seg}, 16'h000F);
        check("rst_bcd", {12'd0, digit_bcd}, 16'h000F);
        check("rst_ack", {15'd0, upd_ack}, 16'h0000);
        check("rst_src", {15'd0, source_ind}, 16'h0000);
        upd_req = 1'b0;
        model_reset();
        @(negedge clock);
        check_model();
        reset = 1'b0;
        hold(2 * FRAME);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
